ps2_key_decoder: RTL and testbench



---
 rtl/ps2_key_decoder_if.sv | 39 +++
 rtl/ps2_key_decoder.sv | 211 +++++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : ps2_key_decoder_if
// Description : PS/2 keyboard pins plus decoded key levels and byte strobes.
//               The master side is the decoder; the slave side is the consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface ps2_key_decoder_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic       w_press;
  logic       a_press;
  logic       s_press;
  logic       d_press;
  logic       enter_press;
  logic       space_press;
  logic       up_press;
  logic       down_press;
  logic       left_press;
  logic       right_press;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       frame_err;

  modport master (
    input  ps2_clk, ps2_data,
    output w_press, a_press, s_press, d_press, enter_press, space_press,
    output up_press, down_press, left_press, right_press,
    output scan_code, scan_valid, frame_err
  );

  modport slave (
    output ps2_clk, ps2_data,
    input  w_press, a_press, s_press, d_press, enter_press, space_press,
    input  up_press, down_press, left_press, right_press,
    input  scan_code, scan_valid, frame_err
  );
endinterface
`default_nettype wire

// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ps2_key_decoder
// Description : PS/2 (scan set 2) receiver with clock glitch filter, frame
//               validation, timeout and make/break tracking. Drives held-key
//               levels for the game keys.
//               Optional macro KBD_ARROW_KEYS_EN enables the E0-prefixed arrow
//               key table; when undefined the arrow outputs are tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_decoder #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 10000
) (
  input  wire logic         clk,
  input  wire logic         rst,
  ps2_key_decoder_if.master kbd
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state, state_nxt;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic [FW-1:0] filt_cnt;
  logic          clk_filt, clk_filt_d;
  logic          fall;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit, accept, reject;
  logic          brk, ext;
  logic [5:0]    main_keys;   // {space, enter, d, s, a, w}
  logic [7:0]    scan_code;
  logic          scan_valid, frame_err;

  // Two-stage synchronisers; idle-high reset so no false edge after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= kbd.ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= kbd.ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // Filtered clock follows the input only after FILTER_LEN differing samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_cnt   <= '0;
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
    end else begin
      clk_filt_d <= clk_filt;
      if (clk_s2 == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  assign fall = clk_filt_d & ~clk_filt;

  // Receiver state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state plus frame accept/reject and timeout decisions
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    reject    = 1'b0;
    tmo_hit   = (state != IDLE) && !fall && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
    if (tmo_hit) begin
      state_nxt = IDLE;
    end else if (fall) begin
      case (state)
        IDLE:    if (!dat_s2) state_nxt = DATA;
        DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
        PARITY:  state_nxt = STOP;
        STOP: begin
          state_nxt = IDLE;
          // odd parity over data+parity and a high stop bit
          if (dat_s2 && (^{shreg, par_bit})) accept = 1'b1;
          else                               reject = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Mid-frame inactivity counter, restarted by every falling edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (state == IDLE || fall || tmo_hit) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  // Bit shifting: data LSB first, then the parity bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= 3'd0;
      shreg   <= 8'h00;
      par_bit <= 1'b0;
    end else if (fall) begin
      case (state)
        IDLE: bit_cnt <= 3'd0;
        DATA: begin
          shreg   <= {dat_s2, shreg[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
        end
        PARITY: par_bit <= dat_s2;
        default: ;
      endcase
    end
  end

`ifdef KBD_ARROW_KEYS_EN
  logic [3:0] arrow_keys;     // {right, left, down, up}
`endif

  // Byte strobes and make/break decoding of every accepted byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_code  <= 8'h00;
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
      brk        <= 1'b0;
      ext        <= 1'b0;
      main_keys  <= '0;
`ifdef KBD_ARROW_KEYS_EN
      arrow_keys <= '0;
`endif
    end else begin
      scan_valid <= accept;
      frame_err  <= reject | tmo_hit;
      if (accept) begin
        scan_code <= shreg;
        if (shreg == 8'hF0) begin
          brk <= 1'b1;
        end else if (shreg == 8'hE0) begin
          ext <= 1'b1;
        end else begin
          brk <= 1'b0;
          ext <= 1'b0;
          if (!ext) begin
            case (shreg)
              8'h1D:   main_keys[0] <= ~brk;
              8'h1C:   main_keys[1] <= ~brk;
              8'h1B:   main_keys[2] <= ~brk;
              8'h23:   main_keys[3] <= ~brk;
              8'h5A:   main_keys[4] <= ~brk;
              8'h29:   main_keys[5] <= ~brk;
              default: ;
            endcase
          end
`ifdef KBD_ARROW_KEYS_EN
          else begin
            case (shreg)
              8'h75:   arrow_keys[0] <= ~brk;
              8'h72:   arrow_keys[1] <= ~brk;
              8'h6B:   arrow_keys[2] <= ~brk;
              8'h74:   arrow_keys[3] <= ~brk;
              default: ;
            endcase
          end
`endif
        end
      end
    end
  end

  assign kbd.w_press     = main_keys[0];
  assign kbd.a_press     = main_keys[1];
  assign kbd.s_press     = main_keys[2];
  assign kbd.d_press     = main_keys[3];
  assign kbd.enter_press = main_keys[4];
  assign kbd.space_press = main_keys[5];
`ifdef KBD_ARROW_KEYS_EN
  assign kbd.up_press    = arrow_keys[0];
  assign kbd.down_press  = arrow_keys[1];
  assign kbd.left_press  = arrow_keys[2];
  assign kbd.right_press = arrow_keys[3];
`else
  assign kbd.up_press    = 1'b0;
  assign kbd.down_press  = 1'b0;
  assign kbd.left_press  = 1'b0;
  assign kbd.right_press = 1'b0;
`endif
  assign kbd.scan_code   = scan_code;
  assign kbd.scan_valid  = scan_valid;
  assign kbd.frame_err   = frame_err;
endmodule
`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_key_decoder
// Description : Self-checking bench for ps2_key_decoder. Frames are driven at
//               PS/2 bit level; a byte-level held-key model predicts outputs.
//               Honours KBD_ARROW_KEYS_EN in the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_key_decoder;
  localparam int FILTER_LEN  = 8;
  localparam int TIMEOUT_CYC = 10000;
  localparam int HALF        = 20;   // clk cycles per PS/2 clock phase

  logic clk = 1'b0;
  logic rst = 1'b1;

  ps2_key_decoder_if kbd();

  ps2_key_decoder #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk (clk),
    .rst (rst),
    .kbd (kbd)
  );

  always #5 clk = ~clk;

  // key vector: bit0 w,1 a,2 s,3 d,4 enter,5 space,6 up,7 down,8 left,9 right
  logic [9:0] keys;
  assign keys = {kbd.right_press, kbd.left_press, kbd.down_press, kbd.up_press,
                 kbd.space_press, kbd.enter_press, kbd.d_press, kbd.s_press,
                 kbd.a_press, kbd.w_press};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  int         sv_cnt = 0;
  int         fe_cnt = 0;
  logic [7:0] last_code = 8'h00;
  logic [9:0] snap_keys = '0;
  logic       watch_w = 1'b0;
  logic       w_glitch = 1'b0;

  always @(negedge clk) begin
    if (kbd.scan_valid) begin
      sv_cnt    <= sv_cnt + 1;
      last_code <= kbd.scan_code;
      snap_keys <= keys;
    end
    if (kbd.frame_err) fe_cnt <= fe_cnt + 1;
    if (watch_w && !kbd.w_press) w_glitch <= 1'b1;
  end

  // ---------------- reference model ----------------
  logic [9:0] mkeys = '0;
  bit         mbrk = 1'b0;
  bit         mext = 1'b0;
  int         exp_sv = 0;
  int         exp_fe = 0;
  logic [7:0] exp_code = 8'h00;

  function automatic int key_index(input bit e, input logic [7:0] code);
    if (!e) begin
      case (code)
        8'h1D: return 0;
        8'h1C: return 1;
        8'h1B: return 2;
        8'h23: return 3;
        8'h5A: return 4;
        8'h29: return 5;
        default: return -1;
      endcase
    end
`ifdef KBD_ARROW_KEYS_EN
    case (code)
      8'h75: return 6;
      8'h72: return 7;
      8'h6B: return 8;
      8'h74: return 9;
      default: return -1;
    endcase
`else
    return -1;
`endif
  endfunction

  task automatic model_byte(input logic [7:0] code);
    int idx;
    if (code == 8'hF0)      mbrk = 1'b1;
    else if (code == 8'hE0) mext = 1'b1;
    else begin
      idx = key_index(mext, code);
      if (idx >= 0) mkeys[idx] = !mbrk;
      mbrk = 1'b0;
      mext = 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    kbd.ps2_data = b;
    wait_cyc(HALF);
    kbd.ps2_clk = 1'b0;
    wait_cyc(HALF);
    kbd.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop);
    logic [10:0] bits;
    logic        par;
    bit          good;
    par  = (~(^code)) ^ bad_par;
    bits = {~bad_stop, par, code, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(bits[i]);
    kbd.ps2_data = 1'b1;
    wait_cyc(HALF);
    good = !bad_par && !bad_stop;
    if (good) begin
      model_byte(code);
      exp_sv++;
      exp_code = code;
    end else begin
      exp_fe++;
    end
    check_val($sformatf("scan_valid_count[%02h]", code), sv_cnt, exp_sv);
    check_val($sformatf("frame_err_count[%02h]", code), fe_cnt, exp_fe);
    check_val($sformatf("scan_code[%02h]", code), {24'd0, last_code}, {24'd0, exp_code});
    check_val($sformatf("keys[%02h]", code), {22'd0, keys}, {22'd0, mkeys});
    if (good)
      check_val($sformatf("keys_at_valid[%02h]", code), {22'd0, snap_keys}, {22'd0, mkeys});
  endtask

  logic [7:0] pool [12] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h5A, 8'h29,
                            8'h75, 8'h72, 8'h6B, 8'h74, 8'hF0, 8'hE0};

  initial begin
    kbd.ps2_clk  = 1'b1;
    kbd.ps2_data = 1'b1;
    wait_cyc(4);
    check_val("reset_keys", {22'd0, keys}, 32'd0);
    check_val("reset_scan_code", {24'd0, kbd.scan_code}, 32'd0);
    check_val("reset_strobes", {30'd0, kbd.scan_valid, kbd.frame_err}, 32'd0);
    rst = 1'b0;
    wait_cyc(30);

    // make / break of W
    send_frame(8'h1D, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h1D, 0, 0);

    // bad parity, bad stop, then good S
    send_frame(8'h1B, 1, 0);
    send_frame(8'h1B, 0, 1);
    send_frame(8'h1B, 0, 0);

    // timeout after 4 data bits
    for (int i = 0; i < 5; i++) send_bit((i == 0) ? 1'b0 : 1'b1);
    kbd.ps2_data = 1'b1;
    wait_cyc(TIMEOUT_CYC + 10);
    exp_fe++;
    check_val("timeout_frame_err", fe_cnt, exp_fe);
    check_val("timeout_no_valid", sv_cnt, exp_sv);
    send_frame(8'h5A, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h5A, 0, 0);

    // keypad enter and arrows
    send_frame(8'hE0, 0, 0);
    send_frame(8'h5A, 0, 0);
    send_frame(8'hE0, 0, 0);
    send_frame(8'h75, 0, 0);
    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h75, 0, 0);

    // simultaneous keys, release of one
    send_frame(8'h1D, 0, 0);
    send_frame(8'h29, 0, 0);
    send_frame(8'h23, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h29, 0, 0);

    // typematic repeats of W
    watch_w = 1'b1;
    for (int i = 0; i < 5; i++) send_frame(8'h1D, 0, 0);
    watch_w = 1'b0;
    check_val("typematic_no_glitch", {31'd0, w_glitch}, 32'd0);

    // pending break, then asynchronous reset mid-frame
    send_frame(8'hF0, 0, 0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    kbd.ps2_data = 1'b1;
    wait_cyc(5);
    kbd.ps2_clk = 1'b0;
    wait_cyc(3);
    #3 rst = 1'b1;
    #1;
    check_val("async_rst_keys", {22'd0, keys}, 32'd0);
    check_val("async_rst_scan_code", {24'd0, kbd.scan_code}, 32'd0);
    check_val("async_rst_strobes", {30'd0, kbd.scan_valid, kbd.frame_err}, 32'd0);
    @(negedge clk);
    kbd.ps2_clk = 1'b1;
    wait_cyc(5);
    rst = 1'b0;
    mkeys = '0;
    mbrk  = 1'b0;
    mext  = 1'b0;
    wait_cyc(30);
    send_frame(8'h1D, 0, 0);

    // short clock glitches while idle with data low
    kbd.ps2_data = 1'b0;
    for (int g = 1; g <= 5; g++) begin
      kbd.ps2_clk = 1'b0;
      wait_cyc(g);
      kbd.ps2_clk = 1'b1;
      wait_cyc(15);
    end
    kbd.ps2_data = 1'b1;
    wait_cyc(30);
    check_val("glitch_no_valid", sv_cnt, exp_sv);
    check_val("glitch_no_err", fe_cnt, exp_fe);
    send_frame(8'h1C, 0, 0);

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      logic [7:0] code;
      int         r;
      bit         bp, bs;
      r    = $urandom_range(0, 13);
      code = (r >= 12) ? 8'($urandom) : pool[r];
      bp   = ($urandom_range(0, 9) == 0);
      bs   = ($urandom_range(0, 19) == 0);
      send_frame(code, bp, bs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
